// File: rtl/morra_match_if.sv
// Bus between the Morra match driver, its controller and the game block.
// The master side is the driver; the slave side is the game/controller.
interface morra_match_if;
    logic       go;
    logic [3:0] cfg_rounds;
    logic       START;
    logic [1:0] P1;
    logic [1:0] P2;
    logic [1:0] ROUND;
    logic [1:0] GAME;
    logic       busy;
    logic       done;
    logic [1:0] result;
    logic [4:0] p1_wins;
    logic [4:0] p2_wins;
    logic [4:0] draws;
    logic       err;
    logic [1:0] err_code;

    modport master (
        input  go, cfg_rounds, ROUND, GAME,
        output START, P1, P2, busy, done, result,
               p1_wins, p2_wins, draws, err, err_code
    );

    modport slave (
        output go, cfg_rounds, ROUND, GAME,
        input  START, P1, P2, busy, done, result,
               p1_wins, p2_wins, draws, err, err_code
    );
endinterface

// File: rtl/morra_match_driver.sv
// Two-player LFSR initiator for the Morra Cinese game block: starts a match,
// plays legal moves every other cycle and tallies the round results.
module morra_match_driver #(
    parameter logic [7:0] P1_SEED    = 8'hA5,
    parameter logic [7:0] P2_SEED    = 8'h3C,
    parameter int         MAX_ROUNDS = 31
) (
    input  logic          clk,
    input  logic          rst_n,
    morra_match_if.master bus
);

    typedef enum logic [2:0] {IDLE, STRT, MOVE, CHECK, DONE, ERR} state_t;

    // An all-zero seed would lock the LFSR.
    localparam logic [7:0] SEED1 = (P1_SEED == 8'h00) ? 8'h01 : P1_SEED;
    localparam logic [7:0] SEED2 = (P2_SEED == 8'h00) ? 8'h01 : P2_SEED;
    localparam logic [4:0] MAXR  = 5'(MAX_ROUNDS);

    state_t     state, state_nxt;
    logic [7:0] lfsr1, lfsr2;
    logic [1:0] forbid1, forbid2, last1, last2, mv1, mv2;
    logic [4:0] chk_cnt, p1w, p2w, drw;
    logic       done_r, err_r;
    logic [1:0] code_r, res_r;
    logic       start_o;
    logic [1:0] p1_o, p2_o;
    logic       accept_go, last_chk;

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic logic [1:0] pick_move(input logic [7:0] l, input logic [1:0] forbid);
        logic [1:0] m;
        m = l[1:0];
        if (m == 2'b00) m = l[3:2];
        if (m == 2'b00) m = 2'b01;
        if (m == forbid) m = (m == 2'b11) ? 2'b01 : m + 2'b01;
        return m;
    endfunction

    function automatic logic [4:0] sat_inc(input logic [4:0] c);
        return (c == 5'd31) ? c : c + 5'd1;
    endfunction

    assign mv1       = pick_move(lfsr1, forbid1);
    assign mv2       = pick_move(lfsr2, forbid2);
    assign accept_go = bus.go && (state == IDLE || state == DONE || state == ERR);
    assign last_chk  = (chk_cnt + 5'd1) == MAXR;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start_o   = 1'b0;
        p1_o      = 2'b00;
        p2_o      = 2'b00;
        case (state)
            IDLE, DONE, ERR: if (bus.go) state_nxt = STRT;
            STRT: begin
                start_o   = 1'b1;
                p1_o      = bus.cfg_rounds[3:2];
                p2_o      = bus.cfg_rounds[1:0];
                state_nxt = MOVE;
            end
            MOVE: begin
                p1_o      = mv1;
                p2_o      = mv2;
                state_nxt = CHECK;
            end
            CHECK: begin
                // A void round wins over a finished game or a timeout.
                if (bus.ROUND == 2'b00)     state_nxt = ERR;
                else if (bus.GAME != 2'b00) state_nxt = DONE;
                else if (last_chk)          state_nxt = ERR;
                else                        state_nxt = MOVE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr1   <= SEED1;
            lfsr2   <= SEED2;
            forbid1 <= 2'b00;
            forbid2 <= 2'b00;
            last1   <= 2'b00;
            last2   <= 2'b00;
            chk_cnt <= 5'd0;
            p1w     <= 5'd0;
            p2w     <= 5'd0;
            drw     <= 5'd0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            code_r  <= 2'b00;
            res_r   <= 2'b00;
        end else if (accept_go) begin
            forbid1 <= 2'b00;
            forbid2 <= 2'b00;
            chk_cnt <= 5'd0;
            p1w     <= 5'd0;
            p2w     <= 5'd0;
            drw     <= 5'd0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            code_r  <= 2'b00;
            res_r   <= 2'b00;
        end else if (state == MOVE) begin
            lfsr1 <= lfsr_step(lfsr1);
            lfsr2 <= lfsr_step(lfsr2);
            last1 <= mv1;
            last2 <= mv2;
        end else if (state == CHECK) begin
            chk_cnt <= chk_cnt + 5'd1;
            case (bus.ROUND)
                2'b01: begin
                    p1w     <= sat_inc(p1w);
                    forbid1 <= last1;
                    forbid2 <= 2'b00;
                end
                2'b10: begin
                    p2w     <= sat_inc(p2w);
                    forbid2 <= last2;
                    forbid1 <= 2'b00;
                end
                2'b11: begin
                    drw     <= sat_inc(drw);
                    forbid1 <= 2'b00;
                    forbid2 <= 2'b00;
                end
                default: begin
                    err_r  <= 1'b1;
                    code_r <= 2'b01;
                end
            endcase
            if (bus.ROUND != 2'b00) begin
                if (bus.GAME != 2'b00) begin
                    res_r  <= bus.GAME;
                    done_r <= 1'b1;
                end else if (last_chk) begin
                    err_r  <= 1'b1;
                    code_r <= 2'b10;
                end
            end
        end
    end

    assign bus.START    = start_o;
    assign bus.P1       = p1_o;
    assign bus.P2       = p2_o;
    assign bus.busy     = (state == STRT) || (state == MOVE) || (state == CHECK);
    assign bus.done     = done_r;
    assign bus.result   = res_r;
    assign bus.p1_wins  = p1w;
    assign bus.p2_wins  = p2w;
    assign bus.draws    = drw;
    assign bus.err      = err_r;
    assign bus.err_code = code_r;

endmodule

// File: tb/tb_morra_match_driver.sv
// Bench for morra_match_driver: stub and reference-game opponents, with a
// queue of expected move pairs built from an independent player model.
`timescale 1ns/1ps
module tb_morra_match_driver;

    localparam int MAXR = 31;

    typedef struct packed {
        logic [1:0] p1;
        logic [1:0] p2;
    } mv_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    morra_match_if bus();
    morra_match_driver dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int failures = 0;

    logic       use_game = 1'b0;
    logic [1:0] stub_round = 2'b00;
    logic [1:0] stub_game = 2'b00;
    logic [1:0] g_round, g_game, g_f1, g_f2, g_rc;
    logic [4:0] g_n, g_target, g_w1, g_w2, g_w1n, g_w2n;
    logic       g_void;

    assign bus.ROUND = use_game ? g_round : stub_round;
    assign bus.GAME  = use_game ? g_game  : stub_game;

    // Player model
    logic [7:0] m_l1, m_l2;
    logic [1:0] m_f1, m_f2;
    logic [4:0] m_p1, m_p2, m_dr;
    mv_t        exp_q[$];

    function automatic logic [7:0] tb_step(input logic [7:0] l);
        return {l[6:0], ^(l & 8'hB8)};
    endfunction

    function automatic logic [1:0] tb_move(input logic [7:0] l, input logic [1:0] f);
        logic [1:0] m;
        m = (l[1:0] != 2'b00) ? l[1:0] : (l[3:2] != 2'b00) ? l[3:2] : 2'b01;
        if (m == f) begin
            case (m)
                2'b01:   m = 2'b10;
                2'b10:   m = 2'b11;
                default: m = 2'b01;
            endcase
        end
        return m;
    endfunction

    function automatic logic beats(input logic [1:0] a, input logic [1:0] b);
        return (a == 2'b01 && b == 2'b11) || (a == 2'b10 && b == 2'b01) || (a == 2'b11 && b == 2'b10);
    endfunction

    // Reference game: round result registered on the move edge, game ends after
    // {P1,P2}+4 rounds from START; repeating a winning move voids the round.
    always_comb begin
        g_void = (bus.P1 == g_f1) || (bus.P2 == g_f2);
        g_rc   = (bus.P1 == bus.P2) ? 2'b11 : beats(bus.P1, bus.P2) ? 2'b01 : 2'b10;
        g_w1n  = g_w1 + {4'b0, g_rc == 2'b01};
        g_w2n  = g_w2 + {4'b0, g_rc == 2'b10};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_round <= 2'b00; g_game <= 2'b00; g_f1 <= 2'b00; g_f2 <= 2'b00;
            g_n <= 5'd0; g_target <= 5'd4; g_w1 <= 5'd0; g_w2 <= 5'd0;
        end else if (bus.START) begin
            g_round <= 2'b00; g_game <= 2'b00; g_f1 <= 2'b00; g_f2 <= 2'b00;
            g_n <= 5'd0; g_target <= {1'b0, bus.P1, bus.P2} + 5'd4; g_w1 <= 5'd0; g_w2 <= 5'd0;
        end else if (bus.P1 != 2'b00 && bus.P2 != 2'b00 && g_game == 2'b00) begin
            if (g_void) g_round <= 2'b00;
            else begin
                g_round <= g_rc;
                g_n     <= g_n + 5'd1;
                g_w1    <= g_w1n;
                g_w2    <= g_w2n;
                g_f1    <= (g_rc == 2'b01) ? bus.P1 : 2'b00;
                g_f2    <= (g_rc == 2'b10) ? bus.P2 : 2'b00;
                if (g_n + 5'd1 == g_target)
                    g_game <= (g_w1n > g_w2n) ? 2'b01 : (g_w2n > g_w1n) ? 2'b10 : 2'b11;
            end
        end
    end

    task automatic run_match(input string name, input logic [3:0] cfg, input bit real_game,
                             input logic [1:0] rnd, input int game_at, input logic [1:0] game_code,
                             input bit poke_go, input bit no_repeat);
        mv_t        e;
        logic [1:0] prev1, r, g, exp_code, exp_res;
        bit         ended, exp_done, exp_err;
        int         nchk;
        use_game   = real_game;
        stub_round = 2'b00;
        stub_game  = 2'b00;
        @(negedge clk);
        bus.go = 1'b1;
        bus.cfg_rounds = cfg;
        @(negedge clk);
        bus.go = 1'b0;
        checks++;
        if ({bus.START, bus.busy, bus.P1, bus.P2, bus.done, bus.err, bus.err_code, bus.result,
             bus.p1_wins, bus.p2_wins, bus.draws} !== {2'b11, cfg, 6'b0, 15'b0}) begin
            failures++;
            $display("FAIL %s start: got START=%b busy=%b P1=%b P2=%b done=%b err=%b code=%b res=%b cnt=%0d/%0d/%0d, want START=1 busy=1 P1=%b P2=%b rest 0",
                     name, bus.START, bus.busy, bus.P1, bus.P2, bus.done, bus.err, bus.err_code,
                     bus.result, bus.p1_wins, bus.p2_wins, bus.draws, cfg[3:2], cfg[1:0]);
        end
        m_f1 = 2'b00; m_f2 = 2'b00; m_p1 = 5'd0; m_p2 = 5'd0; m_dr = 5'd0;
        exp_q.delete();
        exp_q.push_back(mv_t'{tb_move(m_l1, 2'b00), tb_move(m_l2, 2'b00)});
        ended = 0; nchk = 0; prev1 = 2'b00;
        exp_done = 0; exp_err = 0; exp_code = 2'b00; exp_res = 2'b00;
        for (int k = 0; k < 40 && !ended; k++) begin
            @(negedge clk);
            if (poke_go && k == 0) bus.go = 1'b1;
            e = exp_q.pop_front();
            checks++;
            if ({bus.START, bus.busy, bus.P1, bus.P2} !== {2'b01, e.p1, e.p2}) begin
                failures++;
                $display("FAIL %s move%0d: got START=%b busy=%b P1=%b P2=%b, want START=0 busy=1 P1=%b P2=%b",
                         name, k, bus.START, bus.busy, bus.P1, bus.P2, e.p1, e.p2);
            end
            if (no_repeat && k > 0) begin
                checks++;
                if (bus.P1 === prev1) begin
                    failures++;
                    $display("FAIL %s repeat%0d: got P1=%b again, want different from previous %b",
                             name, k, bus.P1, prev1);
                end
            end
            prev1 = bus.P1;
            m_l1 = tb_step(m_l1);
            m_l2 = tb_step(m_l2);
            @(negedge clk);
            bus.go = 1'b0;
            checks++;
            if ({bus.START, bus.busy, bus.P1, bus.P2} !== 6'b01_0000) begin
                failures++;
                $display("FAIL %s check%0d: got START=%b busy=%b P1=%b P2=%b, want 0 1 00 00",
                         name, k, bus.START, bus.busy, bus.P1, bus.P2);
            end
            nchk++;
            r = real_game ? g_round : rnd;
            g = real_game ? g_game : ((game_at != 0 && nchk >= game_at) ? game_code : 2'b00);
            stub_round = r;
            stub_game  = g;
            if (r == 2'b00) begin
                exp_err = 1; exp_code = 2'b01; ended = 1;
            end else begin
                case (r)
                    2'b01:   begin m_p1 = (m_p1 == 5'd31) ? m_p1 : m_p1 + 5'd1; m_f1 = e.p1; m_f2 = 2'b00; end
                    2'b10:   begin m_p2 = (m_p2 == 5'd31) ? m_p2 : m_p2 + 5'd1; m_f2 = e.p2; m_f1 = 2'b00; end
                    default: begin m_dr = (m_dr == 5'd31) ? m_dr : m_dr + 5'd1; m_f1 = 2'b00; m_f2 = 2'b00; end
                endcase
                if (g != 2'b00) begin
                    exp_done = 1; exp_res = g; ended = 1;
                end else if (nchk == MAXR) begin
                    exp_err = 1; exp_code = 2'b10; ended = 1;
                end else
                    exp_q.push_back(mv_t'{tb_move(m_l1, m_f1), tb_move(m_l2, m_f2)});
            end
        end
        @(negedge clk);
        checks++;
        if (!ended) begin
            failures++;
            $display("FAIL %s bound: match still running after %0d checks, want it finished", name, nchk);
        end
        checks++;
        if ({bus.START, bus.busy, bus.P1, bus.P2, bus.done, bus.err, bus.err_code, bus.result} !==
            {2'b00, 4'b0000, exp_done, exp_err, exp_code, exp_res}) begin
            failures++;
            $display("FAIL %s end: got START=%b busy=%b P1=%b P2=%b done=%b err=%b code=%b res=%b, want 0 0 00 00 done=%b err=%b code=%b res=%b",
                     name, bus.START, bus.busy, bus.P1, bus.P2, bus.done, bus.err, bus.err_code,
                     bus.result, exp_done, exp_err, exp_code, exp_res);
        end
        checks++;
        if ({bus.p1_wins, bus.p2_wins, bus.draws} !== {m_p1, m_p2, m_dr}) begin
            failures++;
            $display("FAIL %s tally: got %0d/%0d/%0d, want %0d/%0d/%0d", name,
                     bus.p1_wins, bus.p2_wins, bus.draws, m_p1, m_p2, m_dr);
        end
        if (real_game) begin
            checks++;
            if (!(bus.done === 1'b1 && bus.result === g_game && nchk <= 19 &&
                  (bus.p1_wins + bus.p2_wins + bus.draws) >= 4)) begin
                failures++;
                $display("FAIL %s game: got done=%b result=%b checks=%0d rounds=%0d, want done=1 result=%b checks<=19 rounds>=4",
                         name, bus.done, bus.result, nchk, bus.p1_wins + bus.p2_wins + bus.draws, g_game);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        bus.go = 1'b0;
        bus.cfg_rounds = 4'b0000;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.START, bus.busy, bus.P1, bus.P2, bus.done, bus.err, bus.err_code, bus.result,
             bus.p1_wins, bus.p2_wins, bus.draws} !== 27'b0) begin
            failures++;
            $display("FAIL reset: got START=%b busy=%b P1=%b P2=%b done=%b err=%b code=%b res=%b cnt=%0d/%0d/%0d, want all 0",
                     bus.START, bus.busy, bus.P1, bus.P2, bus.done, bus.err, bus.err_code,
                     bus.result, bus.p1_wins, bus.p2_wins, bus.draws);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_l1 = 8'hA5;
        m_l2 = 8'h3C;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.START, bus.busy, bus.P1, bus.P2, bus.done, bus.err} !== 8'b0) begin
            failures++;
            $display("FAIL idle: got START=%b busy=%b P1=%b P2=%b done=%b err=%b, want all 0",
                     bus.START, bus.busy, bus.P1, bus.P2, bus.done, bus.err);
        end
    endtask

    task automatic test_reset_mid_match();
        @(negedge clk);
        bus.go = 1'b1;
        bus.cfg_rounds = 4'b0110;
        @(negedge clk);
        bus.go = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.START, bus.busy, bus.P1, bus.P2} !== 6'b0) begin
            failures++;
            $display("FAIL midreset: got START=%b busy=%b P1=%b P2=%b, want all 0",
                     bus.START, bus.busy, bus.P1, bus.P2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_l1 = 8'hA5;
        m_l2 = 8'h3C;
        run_match("after_reset", 4'b0011, 1'b0, 2'b11, 3, 2'b11, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        run_match("timeout", 4'b1001, 1'b0, 2'b11, 0, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic test_p1_wins();
        run_match("p1_wins", 4'b0101, 1'b0, 2'b01, 5, 2'b11, 1'b1, 1'b1);
    endtask

    task automatic test_void();
        run_match("void", 4'b0000, 1'b0, 2'b00, 0, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_match("b2b", 4'b0010, 1'b0, 2'b10, 3, 2'b10, 1'b0, 1'b0);
    endtask

    task automatic test_real_game();
        run_match("real_game", 4'b0000, 1'b1, 2'b00, 0, 2'b00, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_p1_wins();
        test_void();
        test_back_to_back();
        test_reset_mid_match();
        test_real_game();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached, want all tests complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
